// File: rtl/load_store_unit.sv
// load_store_unit: single-request load/store unit in front of a word-only data memory.
// Loads extract a byte/halfword lane and sign/zero extend it; sb/sh use read-modify-write;
// misaligned or illegal requests answer with an error and never strobe the memory.
//
// Ports:
//   Clk, Rst                  clock, synchronous active-high reset
//   Req_valid / Req_ready     request handshake (ready only when idle)
//   Is_store, Funct3          request kind and RV32I width code
//   Addr, Wdata               byte address and store data
//   Resp_valid, Resp_err      one-cycle completion pulse and its error flag
//   Rdata                     last successful load result
//   Mem_addr                  word-aligned memory address
//   Mem_rd_en, Mem_rdata      read strobe, read data one cycle later
//   Mem_wr_en, Mem_wdata      write strobe and full write word
module load_store_unit (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Req_valid,
  output logic        Req_ready,
  input  logic        Is_store,
  input  logic [2:0]  Funct3,
  input  logic [31:0] Addr,
  input  logic [31:0] Wdata,
  output logic        Resp_valid,
  output logic        Resp_err,
  output logic [31:0] Rdata,
  output logic [31:0] Mem_addr,
  output logic        Mem_rd_en,
  input  logic [31:0] Mem_rdata,
  output logic        Mem_wr_en,
  output logic [31:0] Mem_wdata
);

  typedef enum logic [2:0] {StIdle, StRd, StWait, StWr, StResp} state_e;

  state_e      state_q, state_d;
  logic        is_store_q;
  logic [2:0]  funct3_q;
  logic [1:0]  lane_q;
  logic [15:0] wdata_q;
  logic        err_q;
  logic [31:0] rdata_q;
  logic [31:0] wbuf_q;
  logic [31:0] mem_addr_q;

  logic        accept;
  logic        req_err;
  logic        req_sw;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_val;
  logic [31:0] merged;

  assign accept = Req_valid && (state_q == StIdle);
  assign req_sw = Is_store && (Funct3 == 3'b010);

  // Request legality: illegal width codes first, then alignment of the legal ones.
  always_comb begin
    req_err = 1'b0;
    if (Is_store) begin
      if (Funct3[2] || (Funct3[1:0] == 2'b11)) req_err = 1'b1;
    end else begin
      if ((Funct3 == 3'b011) || (Funct3 == 3'b110) || (Funct3 == 3'b111)) req_err = 1'b1;
    end
    if ((Funct3[1:0] == 2'b01) && Addr[0]) req_err = 1'b1;
    if ((Funct3[1:0] == 2'b10) && (Addr[1:0] != 2'b00)) req_err = 1'b1;
  end

  // Lane extraction from the returned word.
  always_comb begin
    rd_byte = Mem_rdata[7:0];
    case (lane_q)
      2'd0:    rd_byte = Mem_rdata[7:0];
      2'd1:    rd_byte = Mem_rdata[15:8];
      2'd2:    rd_byte = Mem_rdata[23:16];
      default: rd_byte = Mem_rdata[31:24];
    endcase
    rd_half = lane_q[1] ? Mem_rdata[31:16] : Mem_rdata[15:0];
    case (funct3_q)
      3'b000:  load_val = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  load_val = {{16{rd_half[15]}}, rd_half};
      3'b100:  load_val = {24'h0, rd_byte};
      3'b101:  load_val = {16'h0, rd_half};
      default: load_val = Mem_rdata;
    endcase
  end

  // Read-modify-write merge for sb/sh; all untouched bits come from the read word.
  always_comb begin
    merged = Mem_rdata;
    if (funct3_q[0]) begin
      if (lane_q[1]) merged[31:16] = wdata_q;
      else           merged[15:0]  = wdata_q;
    end else begin
      case (lane_q)
        2'd0:    merged[7:0]   = wdata_q[7:0];
        2'd1:    merged[15:8]  = wdata_q[7:0];
        2'd2:    merged[23:16] = wdata_q[7:0];
        default: merged[31:24] = wdata_q[7:0];
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (Req_valid) begin
          if (req_err)     state_d = StResp;
          else if (req_sw) state_d = StWr;
          else             state_d = StRd;
        end
      end
      StRd:    state_d = StWait;
      StWait:  state_d = is_store_q ? StWr : StResp;
      StWr:    state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= StIdle;
      is_store_q <= 1'b0;
      funct3_q   <= 3'b000;
      lane_q     <= 2'b00;
      wdata_q    <= 16'h0;
      err_q      <= 1'b0;
      rdata_q    <= 32'h0;
      wbuf_q     <= 32'h0;
      mem_addr_q <= 32'h0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        is_store_q <= Is_store;
        funct3_q   <= Funct3;
        lane_q     <= Addr[1:0];
        wdata_q    <= Wdata[15:0];
        err_q      <= req_err;
        // Rejected requests leave the memory-side address untouched.
        if (!req_err) mem_addr_q <= {Addr[31:2], 2'b00};
        if (!req_err && req_sw) wbuf_q <= Wdata;
      end
      if (state_q == StWait) begin
        if (is_store_q) wbuf_q  <= merged;
        else            rdata_q <= load_val;
      end
    end
  end

  // Strobes decode straight from the state register.
  assign Req_ready  = (state_q == StIdle);
  assign Resp_valid = (state_q == StResp);
  assign Resp_err   = (state_q == StResp) && err_q;
  assign Mem_rd_en  = (state_q == StRd);
  assign Mem_wr_en  = (state_q == StWr);
  assign Mem_addr   = mem_addr_q;
  assign Mem_wdata  = wbuf_q;
  assign Rdata      = rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small word memory model.
module tb_load_store_unit;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Req_valid;
  logic        Req_ready;
  logic        Is_store;
  logic [2:0]  Funct3;
  logic [31:0] Addr;
  logic [31:0] Wdata;
  logic        Resp_valid;
  logic        Resp_err;
  logic [31:0] Rdata;
  logic [31:0] Mem_addr;
  logic        Mem_rd_en;
  logic [31:0] Mem_rdata;
  logic        Mem_wr_en;
  logic [31:0] Mem_wdata;

  int checks = 0;
  int failures = 0;

  logic [31:0] mem [0:63];

  always #5 Clk = ~Clk;

  load_store_unit dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .Req_valid  (Req_valid),
    .Req_ready  (Req_ready),
    .Is_store   (Is_store),
    .Funct3     (Funct3),
    .Addr       (Addr),
    .Wdata      (Wdata),
    .Resp_valid (Resp_valid),
    .Resp_err   (Resp_err),
    .Rdata      (Rdata),
    .Mem_addr   (Mem_addr),
    .Mem_rd_en  (Mem_rd_en),
    .Mem_rdata  (Mem_rdata),
    .Mem_wr_en  (Mem_wr_en),
    .Mem_wdata  (Mem_wdata)
  );

  // Word memory: writes at the edge ending the strobe cycle, read data one cycle later.
  always @(posedge Clk) begin
    if (Mem_wr_en) mem[Mem_addr[7:2]] <= Mem_wdata;
    if (Mem_rd_en) Mem_rdata <= mem[Mem_addr[7:2]];
  end

  // Observations from the last run_req call.
  int          r_lat, r_nrd, r_nwr, r_rd_cyc, r_wr_cyc, r_busy_rdy;
  logic        r_err, r_overlap;
  logic [31:0] r_waddr, r_wdata;

  // Issues one request and watches up to 10 cycles after acceptance edge E0.
  task automatic run_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd);
    r_lat = -1; r_nrd = 0; r_nwr = 0; r_rd_cyc = -1; r_wr_cyc = -1; r_busy_rdy = 0;
    r_err = 1'bx; r_overlap = 1'b0; r_waddr = 'x; r_wdata = 'x;
    @(negedge Clk);
    Req_valid = 1'b1; Is_store = st; Funct3 = f3; Addr = a; Wdata = wd;
    @(posedge Clk);
    #1 Req_valid = 1'b0;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge Clk);
      if (Mem_rd_en && Mem_wr_en) r_overlap = 1'b1;
      if (Mem_rd_en) begin r_nrd++; r_rd_cyc = cyc; end
      if (Mem_wr_en) begin r_nwr++; r_wr_cyc = cyc; r_waddr = Mem_addr; r_wdata = Mem_wdata; end
      if (Req_ready) r_busy_rdy++;
      if (Resp_valid) begin r_lat = cyc; r_err = Resp_err; break; end
    end
  endtask

  task automatic test_reset();
    // Request presented during reset must not be accepted.
    Rst = 1'b1; Req_valid = 1'b1; Is_store = 1'b1; Funct3 = 3'b010;
    Addr = 32'h10; Wdata = 32'h55;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    Rst = 1'b0; Req_valid = 1'b0;
    checks++;
    if (Req_ready !== 1'b1 || Resp_valid !== 1'b0 || Resp_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl: ready=%b valid=%b err=%b expected 1 0 0",
               Req_ready, Resp_valid, Resp_err);
    end
    checks++;
    if (Rdata !== 32'h0 || Mem_addr !== 32'h0 || Mem_wdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_data: rdata=%h addr=%h wdata=%h expected all 0",
               Rdata, Mem_addr, Mem_wdata);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (Mem_rd_en !== 1'b0 || Mem_wr_en !== 1'b0 || Resp_valid !== 1'b0) begin
        failures++;
        $display("FAIL reset_quiet: rd=%b wr=%b resp=%b expected 0 0 0",
                 Mem_rd_en, Mem_wr_en, Resp_valid);
      end
      @(negedge Clk);
    end
  endtask

  task automatic test_sw_lw();
    run_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
    checks++;
    if (r_lat !== 2 || r_err !== 1'b0) begin
      failures++; $display("FAIL sw_resp: lat=%0d err=%b expected 2 0", r_lat, r_err);
    end
    checks++;
    if (r_nwr !== 1 || r_nrd !== 0 || r_wr_cyc !== 1) begin
      failures++;
      $display("FAIL sw_strobes: wr=%0d rd=%0d wr_cyc=%0d expected 1 0 1", r_nwr, r_nrd, r_wr_cyc);
    end
    checks++;
    if (r_waddr !== 32'h10 || r_wdata !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL sw_word: addr=%h data=%h expected 00000010 deadbeef", r_waddr, r_wdata);
    end
    run_req(1'b0, 3'b010, 32'h10, 32'h0);
    checks++;
    if (r_lat !== 3 || r_err !== 1'b0 || r_rd_cyc !== 1 || r_nrd !== 1 || r_nwr !== 0) begin
      failures++;
      $display("FAIL lw_timing: lat=%0d err=%b rd_cyc=%0d rd=%0d wr=%0d expected 3 0 1 1 0",
               r_lat, r_err, r_rd_cyc, r_nrd, r_nwr);
    end
    checks++;
    if (Rdata !== 32'hDEADBEEF) begin
      failures++; $display("FAIL lw_data: got %h expected deadbeef", Rdata);
    end
    checks++;
    if (r_busy_rdy !== 0) begin
      failures++; $display("FAIL busy_ready: ready high %0d busy cycles expected 0", r_busy_rdy);
    end
  endtask

  task automatic test_load_ext();
    logic [2:0]  f3s [5] = '{3'b000, 3'b000, 3'b100, 3'b001, 3'b101};
    logic [31:0] ads [5] = '{32'h21, 32'h22, 32'h23, 32'h22, 32'h22};
    logic [31:0] exp [5] = '{32'h0000007F, 32'hFFFFFFF0, 32'h00000080,
                             32'hFFFF80F0, 32'h000080F0};
    run_req(1'b1, 3'b010, 32'h20, 32'h80F07F01);
    for (int i = 0; i < 5; i++) begin
      run_req(1'b0, f3s[i], ads[i], 32'h0);
      checks++;
      if (Rdata !== exp[i] || r_lat !== 3 || r_err !== 1'b0 || r_overlap !== 1'b0) begin
        failures++;
        $display("FAIL load_ext[%0d]: rdata=%h lat=%0d err=%b expected %h 3 0",
                 i, Rdata, r_lat, r_err, exp[i]);
      end
    end
  endtask

  task automatic test_sub_word_store();
    run_req(1'b1, 3'b010, 32'h30, 32'h11223344);
    run_req(1'b1, 3'b000, 32'h31, 32'h000000AA);
    checks++;
    if (r_lat !== 4 || r_err !== 1'b0 || r_rd_cyc !== 1 || r_wr_cyc !== 3) begin
      failures++;
      $display("FAIL sb_timing: lat=%0d err=%b rd_cyc=%0d wr_cyc=%0d expected 4 0 1 3",
               r_lat, r_err, r_rd_cyc, r_wr_cyc);
    end
    checks++;
    if (r_waddr !== 32'h30 || r_wdata !== 32'h1122AA44) begin
      failures++;
      $display("FAIL sb_word: addr=%h data=%h expected 00000030 1122aa44", r_waddr, r_wdata);
    end
    run_req(1'b1, 3'b001, 32'h32, 32'h0000BEEF);
    checks++;
    if (r_wdata !== 32'hBEEFAA44 || r_lat !== 4 || r_nwr !== 1 || r_nrd !== 1) begin
      failures++;
      $display("FAIL sh_word: data=%h lat=%0d expected beefaa44 4", r_wdata, r_lat);
    end
  endtask

  task automatic test_errors();
    logic        sts [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [2:0]  f3s [4] = '{3'b010, 3'b001, 3'b011, 3'b100};
    logic [31:0] ads [4] = '{32'h02, 32'h05, 32'h20, 32'h10};
    for (int i = 0; i < 4; i++) begin
      run_req(sts[i], f3s[i], ads[i], 32'hFFFFFFFF);
      checks++;
      if (r_lat !== 1 || r_err !== 1'b1 || r_nrd !== 0 || r_nwr !== 0) begin
        failures++;
        $display("FAIL err[%0d]: lat=%0d err=%b rd=%0d wr=%0d expected 1 1 0 0",
                 i, r_lat, r_err, r_nrd, r_nwr);
      end
      // Last successful load was lhu 0x22 -> 0x000080F0.
      checks++;
      if (Rdata !== 32'h000080F0) begin
        failures++; $display("FAIL err_rdata[%0d]: got %h expected 000080f0", i, Rdata);
      end
    end
    checks++;
    if (mem[4] !== 32'hDEADBEEF) begin
      failures++; $display("FAIL err_mem: word 0x10=%h expected deadbeef", mem[4]);
    end
  endtask

  task automatic test_reset_mid_op();
    @(negedge Clk);
    Req_valid = 1'b1; Is_store = 1'b1; Funct3 = 3'b000; Addr = 32'h31; Wdata = 32'h77;
    @(posedge Clk);                 // E0
    #1 Req_valid = 1'b0;
    @(negedge Clk);                 // cycle 1: RD
    @(negedge Clk);                 // cycle 2: WAIT
    Rst = 1'b1;
    @(negedge Clk);                 // cycle 3
    Rst = 1'b0;
    checks++;
    if (Req_ready !== 1'b1 || Mem_wr_en !== 1'b0 || Resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_state: ready=%b wr=%b resp=%b expected 1 0 0",
               Req_ready, Mem_wr_en, Resp_valid);
    end
    checks++;
    if (Rdata !== 32'h0 || Mem_addr !== 32'h0) begin
      failures++; $display("FAIL rst_mid_regs: rdata=%h addr=%h expected 0 0", Rdata, Mem_addr);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      checks++;
      if (Mem_wr_en !== 1'b0 || Mem_rd_en !== 1'b0 || Resp_valid !== 1'b0) begin
        failures++;
        $display("FAIL rst_mid_quiet: wr=%b rd=%b resp=%b expected 0 0 0",
                 Mem_wr_en, Mem_rd_en, Resp_valid);
      end
    end
    checks++;
    if (mem[12] !== 32'hBEEFAA44) begin
      failures++; $display("FAIL rst_mid_mem: word 0x30=%h expected beefaa44", mem[12]);
    end
  endtask

  task automatic test_back_to_back();
    logic        sts [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic [2:0]  f3s [4] = '{3'b010, 3'b010, 3'b011, 3'b100};
    logic [31:0] ads [4] = '{32'h40, 32'h40, 32'h40, 32'h41};
    int          exp_cyc [4] = '{2, 6, 8, 12};
    logic        exp_err [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] exp_dat [4] = '{32'h0, 32'h12345678, 32'h12345678, 32'h00000056};
    int          resp_cyc [4];
    logic        resp_err [4];
    logic [31:0] resp_dat [4];
    int          idx = 0;
    int          nresp = 0;
    logic        overlap = 1'b0;
    logic        rdy;
    @(negedge Clk);
    Req_valid = 1'b1; Is_store = sts[0]; Funct3 = f3s[0]; Addr = ads[0]; Wdata = 32'h12345678;
    rdy = Req_ready;
    for (int cyc = 1; cyc <= 30 && nresp < 4; cyc++) begin
      @(posedge Clk);
      if (rdy) begin
        idx++;
        #1;
        if (idx < 4) begin
          Is_store = sts[idx]; Funct3 = f3s[idx]; Addr = ads[idx];
        end else begin
          Req_valid = 1'b0;
        end
      end
      @(negedge Clk);
      if (Mem_rd_en && Mem_wr_en) overlap = 1'b1;
      if (Resp_valid) begin
        resp_cyc[nresp] = cyc; resp_err[nresp] = Resp_err; resp_dat[nresp] = Rdata;
        nresp++;
      end
      rdy = Req_ready && Req_valid;
    end
    Req_valid = 1'b0;
    checks++;
    if (nresp !== 4 || overlap !== 1'b0) begin
      failures++;
      $display("FAIL b2b_count: responses=%0d overlap=%b expected 4 0", nresp, overlap);
    end
    for (int i = 0; i < 4 && i < nresp; i++) begin
      checks++;
      if (resp_cyc[i] !== exp_cyc[i] || resp_err[i] !== exp_err[i]) begin
        failures++;
        $display("FAIL b2b_resp[%0d]: cycle=%0d err=%b expected %0d %b",
                 i, resp_cyc[i], resp_err[i], exp_cyc[i], exp_err[i]);
      end
      if (i > 0) begin
        checks++;
        if (resp_dat[i] !== exp_dat[i]) begin
          failures++;
          $display("FAIL b2b_data[%0d]: got %h expected %h", i, resp_dat[i], exp_dat[i]);
        end
      end
    end
  endtask

  initial begin
    Rst = 1'b1; Req_valid = 1'b0; Is_store = 1'b0; Funct3 = 3'b000;
    Addr = 32'h0; Wdata = 32'h0;
    test_reset();
    test_sw_lw();
    test_load_ext();
    test_sub_word_store();
    test_errors();
    test_reset_mid_op();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator-side load/store unit between the single-cycle core's execute stage and the word-only data memory. It accepts one RV32I load or store request at a time and drives word-aligned read and write strobes to the memory. Because the memory supports only full-word accesses:

- Byte and halfword loads are built by lane extraction plus sign or zero extension.
- Byte and halfword stores are built as a read-modify-write.
- Misaligned and illegal requests are rejected without any memory access.

## Interface

Parameters: none (32-bit datapath, little-endian, fixed 1-cycle memory read latency).

Ports:
- Clk  input  1  single clock; all state updates on rising edge
- Rst  input  1  synchronous, active-high reset
- Req_valid  input  1  core presents a request
- Req_ready  output  1  unit idle and can accept; high only in IDLE
- Is_store  input  1  1 = store, 0 = load
- Funct3  input  3  RV32I width code: 000 b, 001 h, 010 w, 100 bu, 101 hu (loads); 000 sb, 001 sh, 010 sw (stores)
- Addr  input  32  byte address (rs1 + imm)
- Wdata  input  32  store data (rs2)
- Resp_valid  output  1  one-cycle completion pulse
- Resp_err  output  1  qualified by Resp_valid: misaligned or illegal Funct3
- Rdata  output  32  load result; held until the next successful load response
- Mem_addr  output  32  word-aligned address {Addr[31:2], 2'b00}
- Mem_rd_en  output  1  memory read strobe
- Mem_rdata  input  32  read data, valid the cycle after Mem_rd_en
- Mem_wr_en  output  1  memory write strobe; the memory writes at the edge ending that cycle
- Mem_wdata  output  32  full word to write

## Operation

Acceptance and request capture:
- A request is accepted at an edge where Req_valid & Req_ready.
- Is_store, Funct3, Addr and Wdata are registered at acceptance.
- Inputs are ignored while Req_ready = 0.

States: IDLE, RD, WAIT, WR, RESP.
- IDLE: Req_ready = 1. On acceptance:
  - error → RESP with err = 1
  - load, sb or sh → RD
  - sw → WR
- RD: Mem_rd_en = 1, Mem_addr driven → WAIT.
- WAIT: Mem_rdata is captured.
  - For a load, the extracted and extended value goes to the Rdata register → RESP.
  - For sb/sh, the merged word goes to the write buffer → WR.
- WR: Mem_wr_en = 1, Mem_wdata = write buffer (sw: Wdata unchanged) → RESP.
- RESP: Resp_valid = 1 for exactly one cycle, Resp_err as latched → IDLE.

Error rules (no memory strobe is ever asserted):
- Misaligned: h/hu/sh with Addr[0] = 1; w/sw with Addr[1:0] ≠ 00.
- Illegal Funct3: loads 011, 110, 111; stores ≥ 011.
- Rdata is unchanged on error.

Lane rules (little-endian):
- Byte lane k = Addr[1:0] occupies word[8k+7:8k].
- Halfword: Addr[1] = 0 selects [15:0], Addr[1] = 1 selects [31:16].
- b/h sign-extend from bit 7/15; bu/hu zero-extend.
- sb replaces only lane k with Wdata[7:0]; sh replaces only the selected half with Wdata[15:0]; all other bits come from the read word.

Strobe and address rules:
- Mem_rd_en and Mem_wr_en are never high together.
- Mem_addr is meaningful only when a strobe is high; it otherwise holds its last value.

## Timing

Latency is counted from acceptance edge E0; Resp_valid is high in the cycle after:

| Request | Edges to response | Memory accesses |
|---|---|---|
| Load | E3 | one read |
| sw | E2 | one write |
| sb/sh | E4 | read in cycle 1, write in cycle 3 |
| Error | E1 | none |

- Throughput: Req_ready rises in the cycle after Resp_valid, so the minimum gap from one response to the next acceptance is 1 cycle.
- Reset values: state IDLE, Req_ready = 1, Resp_valid = 0, Resp_err = 0, Rdata = 0, Mem_rd_en = 0, Mem_wr_en = 0, Mem_addr = 0, Mem_wdata = 0.
- Reset mid-operation:
  - Strobes are decoded from the state register, so the strobe of the current state is still driven during the cycle Rst is high.
  - From the next cycle: IDLE, no strobes, no Resp_valid.
  - The aborted request is dropped with no response.
- Reset wins over a simultaneous Req_valid; a request in the Rst cycle is not accepted.

## Test plan

- Reset then sw Addr=0x10 Wdata=0xDEADBEEF → Mem_wr_en one cycle with Mem_addr=0x10, Mem_wdata=0xDEADBEEF; Resp_valid at E2, err=0. Then lw 0x10 → Mem_rd_en at cycle 1; Resp_valid at E3 with Rdata=0xDEADBEEF.
- Loads from word 0x80F07F01 at 0x20:
  - lb 0x21 → 0x0000007F
  - lb 0x22 → 0xFFFFFFF0
  - lbu 0x23 → 0x00000080
  - lh 0x22 → 0xFFFF80F0
  - lhu 0x22 → 0x000080F0
- Memory word 0x11223344 at 0x30:
  - sb 0x31 Wdata=0xAA → write 0x1122AA44 at E3, Resp_valid at E4.
  - Then sh 0x32 Wdata=0xBEEF → write 0xBEEFAA44.
- Errors: lw 0x02, sh 0x05, lb with Funct3=011, sw with Funct3=100 → each gives Resp_valid at E1 with err=1, no strobes, Rdata unchanged.
- Rst asserted during WAIT of an sb → no Mem_wr_en, no Resp_valid, Req_ready=1 the cycle after Rst; the memory word is unchanged.
- Req_valid held high across back-to-back requests → each acceptance happens only while Req_ready=1; no strobe overlap; responses are in order.
